// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: load and ALU valid/ready requesters plus the
// registered register-file write port.
interface wb_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  mem_valid;
  logic [ADDR_WIDTH-1:0] mem_rd;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_ready;
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;
  logic                  wb_sel;
  logic                  wb_we;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    output mem_ready, alu_ready, wb_sel, wb_we, wb_rd, wb_data
  );

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
    input  mem_ready, alu_ready, wb_sel, wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: memory-priority with ALU starvation guard, or
// round-robin when WB_ARB_RR_EN is defined.
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  logic                  grant_mem;
  logic                  grant_alu;
  logic                  contended;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wb_sel_q;
  logic                  wb_we_q;
  logic [ADDR_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

`ifdef WB_ARB_RR_EN
  typedef enum logic {PREF_ALU, PREF_MEM} rr_state_e;
  rr_state_e rr_state, rr_next;
`else
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);
  logic [CW-1:0] starve_cnt, starve_next;
`endif

  assign contended = bus.mem_valid && bus.alu_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef WB_ARB_RR_EN
      rr_state   <= PREF_ALU;
`else
      starve_cnt <= '0;
`endif
    end else begin
`ifdef WB_ARB_RR_EN
      rr_state   <= rr_next;
`else
      starve_cnt <= starve_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
`ifdef WB_ARB_RR_EN
    rr_next = rr_state;
    if (contended) rr_next = grant_alu ? PREF_MEM : PREF_ALU;
`else
    starve_next = '0;
    if (bus.alu_valid && !grant_alu)
      starve_next = (starve_cnt == MAX_CNT) ? starve_cnt : starve_cnt + 1'b1;
`endif
  end

  // Grant decode; readies are forced low while reset is asserted
  always_comb begin
    grant_mem = 1'b0;
    grant_alu = 1'b0;
    if (rst_n) begin
      if (contended) begin
`ifdef WB_ARB_RR_EN
        grant_alu = (rr_state == PREF_ALU);
`else
        grant_alu = (starve_cnt == MAX_CNT);
`endif
        grant_mem = !grant_alu;
      end else begin
        grant_mem = bus.mem_valid;
        grant_alu = bus.alu_valid;
      end
    end
  end

  assign bus.mem_ready = grant_mem;
  assign bus.alu_ready = grant_alu;
  assign sel_rd        = grant_mem ? bus.mem_rd   : bus.alu_rd;
  assign sel_data      = grant_mem ? bus.mem_data : bus.alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_sel_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (grant_mem || grant_alu) begin
      wb_sel_q  <= grant_mem;
      wb_we_q   <= |sel_rd;
      wb_rd_q   <= sel_rd;
      wb_data_q <= sel_data;
    end else begin
      wb_we_q   <= 1'b0;
    end
  end

  assign bus.wb_sel  = wb_sel_q;
  assign bus.wb_we   = wb_we_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a behavioural model
// of the grant rules; follows WB_ARB_RR_EN like the design.
module tb_wb_arbiter;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // Model state: ALU consecutive-loss count, last contended winner, wb regs
  int          losses;
  bit          last_alu;
  bit          e_mr, e_ar;
  bit          e_we, e_sel;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  logic        dut_ar;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    losses = 0; last_alu = 1'b0;
    e_we = 1'b0; e_sel = 1'b0; e_rd = '0; e_data = '0;
  endtask

  task automatic model_grant();
    e_mr = 1'b0; e_ar = 1'b0;
    if (bus.mem_valid && bus.alu_valid) begin
`ifdef WB_ARB_RR_EN
      e_ar = !last_alu;
`else
      e_ar = (losses >= MAX_WAIT);
`endif
      e_mr = !e_ar;
    end else begin
      e_mr = bus.mem_valid;
      e_ar = bus.alu_valid;
    end
  endtask

  // One clock: check mid-cycle at negedge, advance model at posedge, return at posedge+1
  task automatic cycle();
    @(negedge clk);
    model_grant();
    dut_ar = bus.alu_ready;
    check("mem_ready", bus.mem_ready, e_mr);
    check("alu_ready", bus.alu_ready, e_ar);
    check("wb_we",   bus.wb_we,   e_we);
    check("wb_sel",  bus.wb_sel,  e_sel);
    check("wb_rd",   bus.wb_rd,   e_rd);
    check("wb_data", bus.wb_data, e_data);
    @(posedge clk);
    if (e_mr) begin
      e_sel = 1'b1; e_rd = bus.mem_rd; e_data = bus.mem_data; e_we = (bus.mem_rd != 0);
    end else if (e_ar) begin
      e_sel = 1'b0; e_rd = bus.alu_rd; e_data = bus.alu_data; e_we = (bus.alu_rd != 0);
    end else begin
      e_we = 1'b0;
    end
`ifdef WB_ARB_RR_EN
    if (bus.mem_valid && bus.alu_valid) last_alu = e_ar;
`else
    if (bus.alu_valid && !e_ar) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
    else losses = 0;
`endif
    #1;
  endtask

  task automatic new_mem(input bit v);
    bus.mem_valid = v;
    bus.mem_rd    = 5'($urandom_range(1, 31));
    bus.mem_data  = $urandom;
  endtask

  task automatic new_alu(input bit v);
    bus.alu_valid = v;
    bus.alu_rd    = 5'($urandom_range(1, 31));
    bus.alu_data  = $urandom;
  endtask

  initial begin
    bit exp_pat;
    model_reset();
    new_mem(1'b0);
    new_alu(1'b0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_we",   bus.wb_we,   1'b0);
    check("rst_wb_sel",  bus.wb_sel,  1'b0);
    check("rst_wb_rd",   bus.wb_rd,   5'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Sustained contention straight after reset
    new_mem(1'b1);
    new_alu(1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle();
`ifdef WB_ARB_RR_EN
      exp_pat = (i % 2 == 0);
`else
      exp_pat = (i % 5 == 4);
`endif
      check("grant_pattern_alu", dut_ar, exp_pat);
      if (e_mr) new_mem(1'b1);
      if (e_ar) new_alu(1'b1);
    end
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    cycle();

    // Single load
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'hDEADBEEF;
    cycle();
    bus.mem_valid = 1'b0;
    check("load_we",   bus.wb_we,   1'b1);
    check("load_sel",  bus.wb_sel,  1'b1);
    check("load_rd",   bus.wb_rd,   5'd5);
    check("load_data", bus.wb_data, 32'hDEADBEEF);
    cycle();

    // x0 write: accepted, data captured, no write enable
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    cycle();
    bus.alu_valid = 1'b0;
    check("x0_we",   bus.wb_we,   1'b0);
    check("x0_sel",  bus.wb_sel,  1'b0);
    check("x0_data", bus.wb_data, 32'h1234);
    cycle();

    // Streaming ALU results, rd 1..8
    for (int i = 1; i <= 8; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'(i); bus.alu_data = 32'(i * 32'h11);
      cycle();
      check("stream_we",   bus.wb_we,   1'b1);
      check("stream_rd",   bus.wb_rd,   5'(i));
      check("stream_data", bus.wb_data, 32'(i * 32'h11));
    end
    bus.alu_valid = 1'b0;
    cycle();

    // Reset mid-stream while a write is being presented
    new_mem(1'b1);
    new_alu(1'b1);
    cycle();
    check("pre_rst_we", bus.wb_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",        bus.wb_we,     1'b0);
    check("mid_rst_sel",       bus.wb_sel,    1'b0);
    check("mid_rst_rd",        bus.wb_rd,     5'd0);
    check("mid_rst_data",      bus.wb_data,   32'd0);
    check("mid_rst_mem_ready", bus.mem_ready, 1'b0);
    check("mid_rst_alu_ready", bus.alu_ready, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    model_reset();
    #1;

    // Randomized traffic; requesters hold until accepted
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (e_mr || !bus.mem_valid) begin
        new_mem($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 7) == 0) bus.mem_rd = '0;
      end
      if (e_ar || !bus.alu_valid) begin
        new_alu($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 7) == 0) bus.alu_rd = '0;
      end
    end
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter for the compressed-ISA core. Shares the single register-file write port between the load path (memory read data) and the ALU result path using valid/ready handshakes. Drives the select of the writeback 2:1 mux (1 = memory, 0 = ALU) together with a registered write enable, destination register and data. Fixed priority goes to memory, with a starvation counter that guarantees ALU progress; a round-robin policy is available as a compile option.

## Interface
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 5, register index width
- MAX_WAIT, 4, max consecutive cycles ALU may lose arbitration (fixed-priority mode); must be >= 1

- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_valid  in  1  load result available
- mem_rd  in  ADDR_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load data
- mem_ready  out  1  load result accepted this cycle
- alu_valid  in  1  ALU result available
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- wb_sel  out  1  writeback mux select, 1 = memory, 0 = ALU
- wb_we  out  1  register-file write enable
- wb_rd  out  ADDR_WIDTH  register-file write index
- wb_data  out  DATA_WIDTH  register-file write data

## Operation
- Handshake: a transfer occurs when valid && ready are both high at a rising clk edge. A requester holds valid high with a stable payload until it sees ready. Ready is combinational from both valids and the arbiter state. At most one ready is high per cycle.
- Grant rules:
  - Only one valid: that requester is granted.
  - Neither valid: no grant.
  - Both valid, fixed mode: memory is granted unless starve_cnt == MAX_WAIT, in which case the ALU is granted.
- starve_cnt, width $clog2(MAX_WAIT+1):
  - Increments when alu_valid && !alu_ready.
  - Clears to 0 on any ALU transfer or when alu_valid is low.
  - Saturates at MAX_WAIT.
- Output stage, updated on every transfer:
  - wb_sel, wb_rd and wb_data capture the granted requester.
  - wb_we = 1 unless the captured rd == 0.
- rd == 0 (x0): the request is still accepted (ready high) and the output registers still update, but wb_we stays 0.
- Cycle with no transfer: wb_we = 0. wb_sel, wb_rd and wb_data hold their last values.

## Timing
- Reset values (asynchronous, immediate on rst_n low): wb_we = 0, wb_sel = 0, wb_rd = 0, wb_data = 0, starve_cnt = 0, RR pointer = ALU preferred.
- mem_ready and alu_ready are 0 while rst_n is low.
- Latency: a transfer at edge N produces wb_* valid during the cycle after edge N, i.e. one cycle.
- Throughput: one writeback per cycle. Back-to-back transfers produce wb_we high on consecutive cycles, in grant order.
- Reset mid-operation: the output write is dropped. Any request not yet accepted is retried by the requester after reset and is not retained by the arbiter.
- Ordering between the two requesters for the same rd is the issue logic's responsibility; the arbiter guarantees only per-requester in-order delivery.

## Configuration
- WB_ARB_RR_EN defined: round-robin policy.
  - When both are valid, the requester not granted last on a contended cycle wins.
  - The pointer updates only on contended grants. The first contention after reset goes to the ALU.
  - starve_cnt is not implemented and MAX_WAIT is ignored.
- WB_ARB_RR_EN undefined: fixed memory priority with the starvation counter, as described above.

## Test plan
- Reset: pull rst_n low mid-stream while wb_we = 1 → all outputs 0 in the same cycle, no ready asserted. Release rst_n → normal operation resumes.
- Single load: mem_valid, mem_rd = 5, mem_data = 0xDEADBEEF → mem_ready high that cycle. Next cycle: wb_we = 1, wb_sel = 1, wb_rd = 5, wb_data = 0xDEADBEEF.
- Sustained contention, fixed mode, MAX_WAIT = 4: both valid every cycle → grant pattern M,M,M,M,A repeating, and starve_cnt returns to 0 after each A.
- x0 write: alu_valid, alu_rd = 0, alu_data = 0x1234 → alu_ready = 1. Next cycle: wb_we = 0, wb_sel = 0, wb_data = 0x1234.
- Round-robin (WB_ARB_RR_EN): both valid for 6 cycles right after reset → grants A,M,A,M,A,M with alternating wb_sel.
- Streaming: 8 back-to-back ALU results with rd = 1..8 and data = rd*0x11 → wb_we high for 8 consecutive cycles, with rd and data in order.
